// File: rtl/ov_cfg_sequencer.sv
// ov_cfg_sequencer: walks a combinational init table and issues one SCCB register write per entry.
// Build option OV_CFG_DELAY_CMD_EN: entries with subaddress 8'hFF become data-ms delays instead of writes.
module ov_cfg_sequencer #(
    parameter int unsigned CLK_FREQ_HZ = 25_000_000,
    parameter int unsigned TABLE_LEN   = 192,
    parameter int unsigned POWERUP_MS  = 20,
    parameter int unsigned GAP_CYCLES  = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  rom_index,
    input  logic [15:0] rom_entry,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_addr,
    output logic [7:0]  cmd_data,
    input  logic        cmd_done,
    output logic        busy,
    output logic        init_done
);

    localparam int unsigned CYC_PER_MS = CLK_FREQ_HZ / 1000;
    localparam int unsigned PWR_CYCLES = POWERUP_MS * CYC_PER_MS;
    localparam int unsigned DLY_MAX    = 255 * CYC_PER_MS;
    localparam int unsigned CNT_MAX0   = (PWR_CYCLES > DLY_MAX) ? PWR_CYCLES : DLY_MAX;
    localparam int unsigned CNT_MAX    = (CNT_MAX0 > GAP_CYCLES) ? CNT_MAX0 : GAP_CYCLES;
    localparam int unsigned CNT_W      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'((PWR_CYCLES == 0) ? 0 : PWR_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [7:0]       LAST_IDX = 8'(TABLE_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        PWRUP,
        FETCH,
        ISSUE,
        WAIT_DONE,
        GAP,
`ifdef OV_CFG_DELAY_CMD_EN
        DLY,
`endif
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    state_t           adv_state;
    state_t           done_state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             handshake;
    logic             got_done;

    assign cnt_zero   = (cnt == '0);
    assign handshake  = (state == ISSUE) && cmd_ready;
    // A cmd_done coinciding with the transfer cycle counts, otherwise only WAIT_DONE listens.
    assign got_done   = ((state == WAIT_DONE) || handshake) && cmd_done;
    assign adv_state  = (rom_index == LAST_IDX) ? DONE : FETCH;
    assign done_state = (GAP_CYCLES == 0) ? adv_state : GAP;

`ifdef OV_CFG_DELAY_CMD_EN
    logic             is_delay;
    logic [CNT_W-1:0] dly_cycles;

    assign is_delay   = (rom_entry[15:8] == 8'hFF);
    assign dly_cycles = CNT_W'(rom_entry[7:0]) * CNT_W'(CYC_PER_MS);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = PWRUP;
            PWRUP:      if (cnt_zero) state_next = FETCH;
            FETCH: begin
                state_next = ISSUE;
`ifdef OV_CFG_DELAY_CMD_EN
                if (is_delay) state_next = (dly_cycles != '0) ? DLY : adv_state;
`endif
            end
            ISSUE:      if (handshake) state_next = got_done ? done_state : WAIT_DONE;
            WAIT_DONE:  if (got_done) state_next = done_state;
            GAP:        if (cnt_zero) state_next = adv_state;
`ifdef OV_CFG_DELAY_CMD_EN
            DLY:        if (cnt_zero) state_next = adv_state;
`endif
            default:    state_next = IDLE;
        endcase
    end

    // Counter loads on state entry and counts down to zero; FETCH entered from anywhere but PWRUP means the next entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            rom_index <= '0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
        end else begin
            if (state_next != state) begin
                case (state_next)
                    PWRUP:   cnt <= PWR_LOAD;
                    GAP:     cnt <= GAP_LOAD;
`ifdef OV_CFG_DELAY_CMD_EN
                    DLY:     cnt <= dly_cycles - 1'b1;
`endif
                    default: cnt <= '0;
                endcase
            end else if (!cnt_zero) begin
                cnt <= cnt - 1'b1;
            end

            if (state_next == PWRUP) begin
                rom_index <= 8'd0;
            end else if (state_next == FETCH) begin
                rom_index <= (state == PWRUP) ? 8'd0 : rom_index + 8'd1;
            end

            if (state == FETCH) begin
                cmd_addr <= rom_entry[15:8];
                cmd_data <= rom_entry[7:0];
            end
        end
    end

    always_comb begin
        cmd_valid = (state == ISSUE);
        busy      = !((state == IDLE) || (state == DONE));
        init_done = (state == DONE);
    end

endmodule
